alu_rs: RTL

Reservation station for the integer ALU: holds up to RS_SIZE dispatched non-memory instructions and tracks their operand tags. It snoops the ALU and LSB common data buses to capture pending operands, and issues one ready instruction per cycle on registered outputs. Upstream is the dispatcher/decoder. Downstream is the combinational ALU, whose CDB output appears in the same cycle as the issue.

---
 rtl/alu_rs.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/alu_rs.sv
// rtl/alu_rs.sv - integer ALU reservation station with dual-CDB snooping and in-order-by-index issue
module alu_rs #(
  parameter int RS_SIZE   = 16,
  parameter int ROB_WIDTH = 4,
  parameter int OP_WIDTH  = 6
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear,
  input  logic                 dispatch_s,
  input  logic [OP_WIDTH-1:0]  dispatch_op,
  input  logic [31:0]          dispatch_vj,
  input  logic [31:0]          dispatch_vk,
  input  logic                 dispatch_qj_s,
  input  logic                 dispatch_qk_s,
  input  logic [ROB_WIDTH-1:0] dispatch_qj,
  input  logic [ROB_WIDTH-1:0] dispatch_qk,
  input  logic [ROB_WIDTH-1:0] dispatch_reorder,
  input  logic [31:0]          dispatch_a,
  input  logic [31:0]          dispatch_pc,
  output logic                 full,
  input  logic                 CDB_ALU_S,
  input  logic [ROB_WIDTH-1:0] CDB_ALU_Reorder,
  input  logic [31:0]          CDB_ALU_Value,
  input  logic                 CDB_LSB_S,
  input  logic [ROB_WIDTH-1:0] CDB_LSB_Reorder,
  input  logic [31:0]          CDB_LSB_Value,
  output logic                 ALU_S,
  output logic [OP_WIDTH-1:0]  Op,
  output logic [31:0]          Vj,
  output logic [31:0]          Vk,
  output logic [ROB_WIDTH-1:0] Reorder,
  output logic [31:0]          A,
  output logic [31:0]          pc
);
  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0]   busy, qj_s, qk_s;
  logic [OP_WIDTH-1:0]  op_q      [RS_SIZE];
  logic [31:0]          vj_q      [RS_SIZE];
  logic [31:0]          vk_q      [RS_SIZE];
  logic [ROB_WIDTH-1:0] qj_q      [RS_SIZE];
  logic [ROB_WIDTH-1:0] qk_q      [RS_SIZE];
  logic [ROB_WIDTH-1:0] reorder_q [RS_SIZE];
  logic [31:0]          a_q       [RS_SIZE];
  logic [31:0]          pc_q      [RS_SIZE];

  logic             free_found, ready_found;
  logic [IDX_W-1:0] free_idx, ready_idx;

  // Scanning high-to-low lets the lowest matching index overwrite the result last.
  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    ready_found = 1'b0;
    ready_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (busy[i] && !qj_s[i] && !qk_s[i]) begin
        ready_found = 1'b1;
        ready_idx   = IDX_W'(i);
      end
    end
  end

  assign full = &busy;

  logic        d_qj_s, d_qk_s;
  logic [31:0] d_vj, d_vk;

  // Operands whose producer broadcasts in the dispatch cycle are captured immediately.
  always_comb begin
    d_qj_s = dispatch_qj_s;
    d_vj   = dispatch_vj;
    d_qk_s = dispatch_qk_s;
    d_vk   = dispatch_vk;
    if (dispatch_qj_s) begin
      if (CDB_ALU_S && CDB_ALU_Reorder == dispatch_qj) begin
        d_qj_s = 1'b0;
        d_vj   = CDB_ALU_Value;
      end else if (CDB_LSB_S && CDB_LSB_Reorder == dispatch_qj) begin
        d_qj_s = 1'b0;
        d_vj   = CDB_LSB_Value;
      end
    end
    if (dispatch_qk_s) begin
      if (CDB_ALU_S && CDB_ALU_Reorder == dispatch_qk) begin
        d_qk_s = 1'b0;
        d_vk   = CDB_ALU_Value;
      end else if (CDB_LSB_S && CDB_LSB_Reorder == dispatch_qk) begin
        d_qk_s = 1'b0;
        d_vk   = CDB_LSB_Value;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      busy    <= '0;
      qj_s    <= '0;
      qk_s    <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_q[i]      <= '0;
        vj_q[i]      <= '0;
        vk_q[i]      <= '0;
        qj_q[i]      <= '0;
        qk_q[i]      <= '0;
        reorder_q[i] <= '0;
        a_q[i]       <= '0;
        pc_q[i]      <= '0;
      end
      ALU_S   <= 1'b0;
      Op      <= '0;
      Vj      <= '0;
      Vk      <= '0;
      Reorder <= '0;
      A       <= '0;
      pc      <= '0;
    end else if (rdy_in) begin
      if (clear) begin
        busy    <= '0;
        ALU_S   <= 1'b0;
        Op      <= '0;
        Vj      <= '0;
        Vk      <= '0;
        Reorder <= '0;
        A       <= '0;
        pc      <= '0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i] && qj_s[i]) begin
            if (CDB_ALU_S && CDB_ALU_Reorder == qj_q[i]) begin
              vj_q[i] <= CDB_ALU_Value;
              qj_s[i] <= 1'b0;
            end else if (CDB_LSB_S && CDB_LSB_Reorder == qj_q[i]) begin
              vj_q[i] <= CDB_LSB_Value;
              qj_s[i] <= 1'b0;
            end
          end
          if (busy[i] && qk_s[i]) begin
            if (CDB_ALU_S && CDB_ALU_Reorder == qk_q[i]) begin
              vk_q[i] <= CDB_ALU_Value;
              qk_s[i] <= 1'b0;
            end else if (CDB_LSB_S && CDB_LSB_Reorder == qk_q[i]) begin
              vk_q[i] <= CDB_LSB_Value;
              qk_s[i] <= 1'b0;
            end
          end
        end

        if (ready_found) begin
          ALU_S           <= 1'b1;
          Op              <= op_q[ready_idx];
          Vj              <= vj_q[ready_idx];
          Vk              <= vk_q[ready_idx];
          Reorder         <= reorder_q[ready_idx];
          A               <= a_q[ready_idx];
          pc              <= pc_q[ready_idx];
          busy[ready_idx] <= 1'b0;
        end else begin
          ALU_S   <= 1'b0;
          Op      <= '0;
          Vj      <= '0;
          Vk      <= '0;
          Reorder <= '0;
          A       <= '0;
          pc      <= '0;
        end

        // The dispatch slot was free at cycle start, so it never collides with the issue slot.
        if (dispatch_s && free_found) begin
          busy[free_idx]      <= 1'b1;
          op_q[free_idx]      <= dispatch_op;
          vj_q[free_idx]      <= d_vj;
          vk_q[free_idx]      <= d_vk;
          qj_s[free_idx]      <= d_qj_s;
          qk_s[free_idx]      <= d_qk_s;
          qj_q[free_idx]      <= dispatch_qj;
          qk_q[free_idx]      <= dispatch_qk;
          reorder_q[free_idx] <= dispatch_reorder;
          a_q[free_idx]       <= dispatch_a;
          pc_q[free_idx]      <= dispatch_pc;
        end
      end
    end
  end
endmodule
